// File: rtl/prbs_pkg.sv
// Shared definitions for the PRBS burst controller and its transmitter.
// Latency: n/a (types, constants and a constant function only).
// Backpressure: n/a.
package prbs_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_BURST = 3'd2,
        ST_GAP   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Gap length and gap counter width.
    localparam int GAP_W = 16;
    // Burst count / burst index width.
    localparam int IDX_W = 16;

    // Second feedback tap of the maximal-length polynomial x^N + x^T + 1.
    function automatic int prbs_tap(input int order);
        case (order)
            9:       return 5;
            15:      return 14;
            23:      return 18;
            31:      return 28;
            default: return order - 1;   // PRBS7: x^7 + x^6 + 1
        endcase
    endfunction

endpackage

// File: rtl/prbs_tx.sv
// prbs_tx: Fibonacci LFSR PRBS source; advances one bit per enabled cycle.
// Latency: dout/dout_vld are registered, one cycle after en.
// Backpressure: none; the bit stream simply pauses while en is low.
module prbs_tx
    import prbs_pkg::*;
#(
    parameter int PRBS_TYPE = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic dout,
    output logic dout_vld
);

    localparam int TAP = prbs_tap(PRBS_TYPE);

    logic [PRBS_TYPE-1:0] lfsr;
    logic                 fb;

    // Newest bit sits in lfsr[0]; feedback is the XOR of the two tap ages.
    assign fb = lfsr[PRBS_TYPE-1] ^ lfsr[TAP-1];

    // Shift the LFSR and present the new bit whenever enabled; all-ones seed.
    always_ff @(posedge clk) begin
        if (!rst) begin
            lfsr     <= '1;
            dout     <= 1'b0;
            dout_vld <= 1'b0;
        end else begin
            dout_vld <= en;
            if (en) begin
                lfsr <= {lfsr[PRBS_TYPE-2:0], fb};
                dout <= fb;
            end
        end
    end

endmodule

// File: rtl/prbs_tx_ctrl.sv
// prbs_tx_ctrl: sequences PRBS bursts separated by idle gaps and enables the transmitter.
// Latency: prbs_en rises two cycles after start (one LOAD cycle); every status output is registered.
// Backpressure: none; start is ignored while busy, abort ends any active sequence next cycle.
module prbs_tx_ctrl
    import prbs_pkg::*;
#(
    parameter int PRBS_TYPE = 7,
    parameter int LEN_W     = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [LEN_W-1:0] cfg_burst_len,
    input  logic [GAP_W-1:0] cfg_gap_len,
    input  logic [IDX_W-1:0] cfg_burst_num,
    output logic             prbs_en,
    output logic             dout,
    output logic             dout_vld,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic             cfg_err,
    output logic [IDX_W-1:0] burst_idx
);

    state_t           state, state_d;
    logic [LEN_W-1:0] len_q, bit_cnt, bit_cnt_d;
    logic [GAP_W-1:0] gap_q, gap_cnt, gap_cnt_d;
    logic [IDX_W-1:0] num_q, burst_idx_d;
    logic             prbs_en_d, busy_d, done_d, aborted_d, cfg_err_d;
    logic             burst_end, gap_end, last_burst, new_burst;

    assign burst_end  = (bit_cnt == len_q - LEN_W'(1));
    assign gap_end    = (gap_cnt == gap_q - GAP_W'(1));
    assign last_burst = (num_q != '0) && (burst_idx == num_q - IDX_W'(1));
    // A fresh burst begins after a gap, or back-to-back when there is no gap.
    assign new_burst  = (state_d == ST_BURST) &&
                        ((state == ST_GAP) || ((state == ST_BURST) && burst_end));

    // State, latched configuration, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            len_q     <= '0;
            gap_q     <= '0;
            num_q     <= '0;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
            prbs_en   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
            cfg_err   <= 1'b0;
            burst_idx <= '0;
        end else begin
            state     <= state_d;
            bit_cnt   <= bit_cnt_d;
            gap_cnt   <= gap_cnt_d;
            prbs_en   <= prbs_en_d;
            busy      <= busy_d;
            done      <= done_d;
            aborted   <= aborted_d;
            cfg_err   <= cfg_err_d;
            burst_idx <= burst_idx_d;
            // Configuration is captured once; later input changes have no effect.
            if (state == ST_LOAD) begin
                len_q <= cfg_burst_len;
                gap_q <= cfg_gap_len;
                num_q <= cfg_burst_num;
            end
        end
    end

    // Next-state selection; abort overrides every non-idle transition.
    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE:  if (start && !abort) state_d = ST_LOAD;
            ST_LOAD:  state_d = (cfg_burst_len == '0) ? ST_IDLE : ST_BURST;
            ST_BURST: begin
                if (burst_end) begin
                    if (last_burst)          state_d = ST_DONE;
                    else if (gap_q == '0)    state_d = ST_BURST;
                    else                     state_d = ST_GAP;
                end
            end
            ST_GAP:   if (gap_end) state_d = ST_BURST;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (abort && (state != ST_IDLE)) state_d = ST_IDLE;
    end

    // Next values of outputs and counters, derived from the upcoming state.
    always_comb begin
        prbs_en_d   = (state_d == ST_BURST);
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_DONE);
        aborted_d   = abort && (state != ST_IDLE);
        cfg_err_d   = (state == ST_LOAD) && !abort && (cfg_burst_len == '0);
        bit_cnt_d   = ((state == ST_BURST) && !burst_end) ? bit_cnt + LEN_W'(1) : '0;
        gap_cnt_d   = ((state == ST_GAP) && !gap_end) ? gap_cnt + GAP_W'(1) : '0;
        burst_idx_d = burst_idx;
        if (state_d == ST_LOAD)
            burst_idx_d = '0;
        else if (new_burst)
            burst_idx_d = burst_idx + IDX_W'(1);
    end

    prbs_tx #(
        .PRBS_TYPE (PRBS_TYPE)
    ) u_prbs_tx (
        .clk      (clk),
        .rst      (rst),
        .en       (prbs_en),
        .dout     (dout),
        .dout_vld (dout_vld)
    );

endmodule
